fsm_cmd_decoder: RTL and testbench

FSM_CMD_DECODER -- requirements
Module: fsm_cmd_decoder

---
 rtl/fsm_cmd_decoder.sv | 126 ++++++++++++
 tb/tb_fsm_cmd_decoder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fsm_cmd_decoder.sv
// Command decoder FSM: IDLE/LOAD/RUN/LOCK with one busy cycle after each accepted command.
// Define FSM_ERR_LOCK_EN to force LOCK when the error counter saturates.
module fsm_cmd_decoder #(
  parameter int unsigned ERR_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       cmd_in,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  output logic [1:0]       state_out,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StRun  = 2'd2,
    StLock = 2'd3
  } state_e;

  localparam logic [2:0] CmdNop    = 3'd0;
  localparam logic [2:0] CmdGoLoad = 3'd1;
  localparam logic [2:0] CmdGoRun  = 3'd2;
  localparam logic [2:0] CmdGoIdle = 3'd3;
  localparam logic [2:0] CmdGoLock = 3'd4;

  localparam logic [ERR_W-1:0] CntMax = '1;
  localparam logic [ERR_W-1:0] CntPre = CntMax - 1'b1;

  state_e           state_q;
  logic             ready_q;
  logic             err_q;
  logic [ERR_W-1:0] cnt_q;

  logic   cmd_ok;
  state_e cmd_tgt;
  logic   accept;

  assign accept = cmd_valid && ready_q && (cmd_in != CmdNop);

  // Legality and target of the presented command from the current state.
  always_comb begin
    cmd_ok  = 1'b0;
    cmd_tgt = state_q;
    case (state_q)
      StIdle: begin
        if (cmd_in == CmdGoLoad) begin
          cmd_ok  = 1'b1;
          cmd_tgt = StLoad;
        end else if (cmd_in == CmdGoLock) begin
          cmd_ok  = 1'b1;
          cmd_tgt = StLock;
        end
      end
      StLoad: begin
        if (cmd_in == CmdGoRun) begin
          cmd_ok  = 1'b1;
          cmd_tgt = StRun;
        end else if (cmd_in == CmdGoIdle) begin
          cmd_ok  = 1'b1;
          cmd_tgt = StIdle;
        end else if (cmd_in == CmdGoLock) begin
          cmd_ok  = 1'b1;
          cmd_tgt = StLock;
        end
      end
      StRun: begin
        if (cmd_in == CmdGoIdle) begin
          cmd_ok  = 1'b1;
          cmd_tgt = StIdle;
        end else if (cmd_in == CmdGoLock) begin
          cmd_ok  = 1'b1;
          cmd_tgt = StLock;
        end
      end
      StLock: begin
        cmd_ok  = 1'b0;
        cmd_tgt = StLock;
      end
      default: begin
        cmd_ok  = 1'b1;
        cmd_tgt = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ready_q <= 1'b1;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      err_q <= 1'b0;
      if (state_q == StLock) begin
        ready_q <= 1'b0;
      end else if (!ready_q) begin
        ready_q <= 1'b1;
      end
      if (accept) begin
        ready_q <= 1'b0;
        if (cmd_ok) begin
          state_q <= cmd_tgt;
        end else begin
          err_q <= 1'b1;
          if (cnt_q != CntMax) begin
            cnt_q <= cnt_q + 1'b1;
          end
`ifdef FSM_ERR_LOCK_EN
          if (cnt_q == CntPre) begin
            state_q <= StLock;
          end
`endif
        end
      end
    end
  end

  assign cmd_ready = ready_q;
  assign state_out = state_q;
  assign err       = err_q;
  assign err_cnt   = cnt_q;

endmodule

// File: tb/tb_fsm_cmd_decoder.sv
// Directed bench for fsm_cmd_decoder: ERR_W=4 main instance plus an ERR_W=2 saturation instance.
module tb_fsm_cmd_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [2:0] cmd0 = 3'd0;
  logic       val0 = 1'b0;
  logic       rdy0;
  logic [1:0] st0;
  logic       err0;
  logic [3:0] cnt0;
  logic [2:0] cmd1 = 3'd0;
  logic       val1 = 1'b0;
  logic       rdy1;
  logic [1:0] st1;
  logic       err1;
  logic [1:0] cnt1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fsm_cmd_decoder #(.ERR_W(4)) dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_in    (cmd0),
    .cmd_valid (val0),
    .cmd_ready (rdy0),
    .state_out (st0),
    .err       (err0),
    .err_cnt   (cnt0)
  );

  fsm_cmd_decoder #(.ERR_W(2)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_in    (cmd1),
    .cmd_valid (val1),
    .cmd_ready (rdy1),
    .state_out (st1),
    .err       (err1),
    .err_cnt   (cnt1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk0(input string tag, input int st, input int rdy, input int er, input int cnt);
    chk({tag, ".state"}, 32'(st0), 32'(st));
    chk({tag, ".ready"}, 32'(rdy0), 32'(rdy));
    chk({tag, ".err"}, 32'(err0), 32'(er));
    chk({tag, ".cnt"}, 32'(cnt0), 32'(cnt));
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are checked at the same point.
  task automatic step0(input logic [2:0] c, input logic v);
    cmd0 = c;
    val0 = v;
    @(posedge clk);
    #1;
  endtask

  task automatic step1(input logic [2:0] c, input logic v);
    cmd1 = c;
    val1 = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_cnt;
    int exp_st;
    logic [2:0] seq_cmd [3];
    int         seq_st  [3];
    seq_cmd[0] = 3'd1; seq_st[0] = 1;
    seq_cmd[1] = 3'd2; seq_st[1] = 2;
    seq_cmd[2] = 3'd3; seq_st[2] = 0;

    // Asynchronous reset before any clock edge
    #2 rst_n = 1'b0;
    #1;
    chk0("reset_async", 0, 1, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Legal walk IDLE->LOAD->RUN->IDLE with valid held through the busy cycle
    for (int i = 0; i < 3; i++) begin
      step0(seq_cmd[i], 1'b1);
      chk0("walk_accept", seq_st[i], 0, 0, 0);
      step0(seq_cmd[i], 1'b1);
      chk0("walk_busy", seq_st[i], 1, 0, 0);
    end

    // NOPs in LOAD never change state or ready
    step0(3'd1, 1'b1);
    chk0("to_load", 1, 0, 0, 0);
    step0(3'd0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step0(3'd0, 1'b1);
      chk0("nop_load", 1, 1, 0, 0);
    end
    step0(3'd3, 1'b1);
    chk0("load_to_idle", 0, 0, 0, 0);
    step0(3'd0, 1'b0);

    // Illegal transition and illegal code from IDLE
    step0(3'd2, 1'b1);
    chk0("run_from_idle", 0, 0, 1, 1);
    step0(3'd0, 1'b0);
    chk0("after_err1", 0, 1, 0, 1);
    step0(3'd6, 1'b1);
    chk0("code6", 0, 0, 1, 2);
    step0(3'd0, 1'b0);
    chk0("after_err2", 0, 1, 0, 2);

    // Illegal codes presented during busy cycles are ignored
    step0(3'd7, 1'b1);
    chk0("code7", 0, 0, 1, 3);
    step0(3'd5, 1'b1);
    chk0("busy_ignore5", 0, 1, 0, 3);
    step0(3'd5, 1'b1);
    chk0("code5", 0, 0, 1, 4);
    step0(3'd6, 1'b0);
    chk0("busy_toggle", 0, 1, 0, 4);
    step0(3'd0, 1'b0);
    chk0("idle_hold", 0, 1, 0, 4);

    // Target equal to current state is rejected
    step0(3'd1, 1'b1);
    step0(3'd0, 1'b0);
    step0(3'd1, 1'b1);
    chk0("load_in_load", 1, 0, 1, 5);
    step0(3'd0, 1'b0);

    // RUN -> LOCK, then LOCK is sticky
    step0(3'd2, 1'b1);
    chk0("to_run", 2, 0, 0, 5);
    step0(3'd0, 1'b0);
    step0(3'd4, 1'b1);
    chk0("to_lock", 3, 0, 0, 5);
    step0(3'd3, 1'b1);
    chk0("lock_idle1", 3, 0, 0, 5);
    step0(3'd3, 1'b1);
    step0(3'd6, 1'b1);
    chk0("lock_stuck", 3, 0, 0, 5);

    // Reset mid-cycle, away from any edge, takes effect immediately
    #2 rst_n = 1'b0;
    #1;
    chk0("reset_in_lock", 0, 1, 0, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset during a busy cycle discards the pending command
    step0(3'd1, 1'b1);
    chk0("load_again", 1, 0, 0, 0);
    cmd0 = 3'd2;
    #2 rst_n = 1'b0;
    #1;
    chk0("reset_in_busy", 0, 1, 0, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    val0 = 1'b0;
    @(posedge clk);
    #1;
    chk0("post_reset_hold", 0, 1, 0, 0);

    // ERR_W=2 saturation, with and without error escalation
    for (int k = 1; k <= 5; k++) begin
      exp_cnt = (k > 3) ? 3 : k;
`ifdef FSM_ERR_LOCK_EN
      exp_st = (k >= 3) ? 3 : 0;
      step1(3'd5 + 3'(k % 3), 1'b1);
      chk("sat.err", 32'(err1), (k > 3) ? 32'd0 : 32'd1);
      chk("sat.cnt", 32'(cnt1), 32'(exp_cnt));
      chk("sat.state", 32'(st1), 32'(exp_st));
      step1(3'd0, 1'b0);
      chk("sat.ready", 32'(rdy1), (k >= 3) ? 32'd0 : 32'd1);
`else
      exp_st = 0;
      step1(3'd5 + 3'(k % 3), 1'b1);
      chk("sat.err", 32'(err1), 32'd1);
      chk("sat.cnt", 32'(cnt1), 32'(exp_cnt));
      chk("sat.state", 32'(st1), 32'(exp_st));
      step1(3'd0, 1'b0);
      chk("sat.ready", 32'(rdy1), 32'd1);
`endif
      chk("sat.err_low", 32'(err1), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
